// File: rtl/i2c_register_target.sv
// I2C target with a 256x8 register file: write = dev, reg, payload (burst auto-increment),
// read via (repeated) START from the persistent pointer. SCL/SDA are oversampled on clock_25.
module i2c_register_target #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h39,
  parameter int         FILTER_CYCLES  = 3,
  parameter logic [7:0] RESET_VALUE    = 8'h00
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic       i2c_serial_clock,
  inout  wire        i2c_serial_data,
  output logic       reg_write_valid,
  output logic [7:0] reg_write_address,
  output logic [7:0] reg_write_data,
  input  logic [7:0] cfg_read_address,
  output logic [7:0] cfg_read_data,
  output logic       busy
);

  localparam int CW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic [1:0]    r_scl_sync, r_sda_sync;
  logic          r_scl_filt, r_sda_filt;
  logic [CW-1:0] r_scl_cnt, r_sda_cnt;
  logic          r_scl_rise, r_scl_fall, r_sda_rise, r_sda_fall;

  state_t        r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_rw;
  logic [1:0]    r_ack_ph;
  logic [7:0]    r_ptr;
  logic          r_sda_low;
  logic [7:0]    r_mem [256];

  logic          w_start, w_stop;
  logic [7:0]    w_byte;

  assign i2c_serial_data = r_sda_low ? 1'b0 : 1'bz;

  // Synchronize, then accept a new level only after FILTER_CYCLES identical samples
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
      r_scl_cnt  <= '0;
      r_sda_cnt  <= '0;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_sda_rise <= 1'b0;
      r_sda_fall <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i2c_serial_clock};
      r_sda_sync <= {r_sda_sync[0], i2c_serial_data};
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_sda_rise <= 1'b0;
      r_sda_fall <= 1'b0;
      if (r_scl_sync[1] == r_scl_filt) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == CNT_LAST) begin
        r_scl_filt <= r_scl_sync[1];
        r_scl_cnt  <= '0;
        r_scl_rise <= r_scl_sync[1];
        r_scl_fall <= ~r_scl_sync[1];
      end else begin
        r_scl_cnt <= r_scl_cnt + 1'b1;
      end
      if (r_sda_sync[1] == r_sda_filt) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == CNT_LAST) begin
        r_sda_filt <= r_sda_sync[1];
        r_sda_cnt  <= '0;
        r_sda_rise <= r_sda_sync[1];
        r_sda_fall <= ~r_sda_sync[1];
      end else begin
        r_sda_cnt <= r_sda_cnt + 1'b1;
      end
    end
  end

  assign w_start = r_sda_fall & r_scl_filt;
  assign w_stop  = r_sda_rise & r_scl_filt;
  assign w_byte  = {r_shift[6:0], r_sda_filt};

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_state           <= IDLE;
      r_bitcnt          <= '0;
      r_shift           <= '0;
      r_rw              <= 1'b0;
      r_ack_ph          <= '0;
      r_ptr             <= '0;
      r_sda_low         <= 1'b0;
      busy              <= 1'b0;
      reg_write_valid   <= 1'b0;
      reg_write_address <= '0;
      reg_write_data    <= '0;
      for (int i = 0; i < 256; i++) r_mem[i] <= RESET_VALUE;
    end else begin
      reg_write_valid <= 1'b0;
      if (w_stop) begin
        r_state   <= IDLE;
        r_sda_low <= 1'b0;
        r_bitcnt  <= '0;
        busy      <= 1'b0;
      end else if (w_start) begin
        // Any partially shifted byte is simply abandoned here
        r_state   <= ADDR;
        r_sda_low <= 1'b0;
        r_bitcnt  <= '0;
      end else begin
        case (r_state)
          ADDR: if (r_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_ack_ph <= '0;
              if (w_byte[7:1] == DEVICE_ADDRESS) begin
                r_rw    <= w_byte[0];
                busy    <= 1'b1;
                r_state <= ADDR_ACK;
              end else begin
                busy    <= 1'b0;
                r_state <= IGNORE;
              end
            end
          end
          ADDR_ACK, REG_ACK, WDATA_ACK: if (r_scl_fall) begin
            if (r_ack_ph == 2'd0) begin
              r_sda_low <= 1'b1;
              r_ack_ph  <= 2'd1;
            end else begin
              r_ack_ph <= '0;
              r_bitcnt <= '0;
              if (r_state == ADDR_ACK && r_rw) begin
                r_shift   <= r_mem[r_ptr];
                r_sda_low <= ~r_mem[r_ptr][7];
                r_state   <= RDATA;
              end else begin
                r_sda_low <= 1'b0;
                r_state   <= (r_state == ADDR_ACK) ? REG : WDATA;
              end
            end
          end
          REG: if (r_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_ptr   <= w_byte;
              r_state <= REG_ACK;
            end
          end
          WDATA: if (r_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_mem[r_ptr]      <= w_byte;
              reg_write_valid   <= 1'b1;
              reg_write_address <= r_ptr;
              reg_write_data    <= w_byte;
              r_ptr             <= r_ptr + 8'd1;
              r_state           <= WDATA_ACK;
            end
          end
          RDATA: begin
            if (r_scl_rise) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_ack_ph <= '0;
                r_state  <= RDATA_ACK;
              end
            end else if (r_scl_fall) begin
              r_shift   <= {r_shift[6:0], 1'b0};
              r_sda_low <= ~r_shift[6];
            end
          end
          // Phase 0: release for the 9th clock; 1: sample master ACK; 2: drive next MSB
          RDATA_ACK: begin
            if (r_ack_ph == 2'd0 && r_scl_fall) begin
              r_sda_low <= 1'b0;
              r_ack_ph  <= 2'd1;
            end else if (r_ack_ph == 2'd1 && r_scl_rise) begin
              r_ptr <= r_ptr + 8'd1;
              if (!r_sda_filt) begin
                r_shift  <= r_mem[r_ptr + 8'd1];
                r_ack_ph <= 2'd2;
              end else begin
                r_state <= IGNORE;
              end
            end else if (r_ack_ph == 2'd2 && r_scl_fall) begin
              r_sda_low <= ~r_shift[7];
              r_bitcnt  <= '0;
              r_ack_ph  <= '0;
              r_state   <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) cfg_read_data <= RESET_VALUE;
    else        cfg_read_data <= r_mem[cfg_read_address];
  end

endmodule

// File: tb/tb_i2c_register_target.sv
// Bench for i2c_register_target: bit-banged I2C master plus a transaction-level register model.
module tb_i2c_register_target;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       tb_sda_low = 1'b0;
  logic [7:0] cfg_addr = 8'h00;
  wire        sda;
  logic       rwv, busy;
  logic [7:0] rwa, rwd, cfg_data;

  pullup (sda);
  assign sda = tb_sda_low ? 1'b0 : 1'bz;

  always #20 clk = ~clk;

  i2c_register_target dut (
    .clock_25(clk), .reset(rst_n), .i2c_serial_clock(scl), .i2c_serial_data(sda),
    .reg_write_valid(rwv), .reg_write_address(rwa), .reg_write_data(rwd),
    .cfg_read_address(cfg_addr), .cfg_read_data(cfg_data), .busy(busy)
  );

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  mem [256];
  logic [7:0]  ptr = 8'h00;
  logic [15:0] exp_q [$];
  logic [7:0]  wdat [8];
  logic [7:0]  rd [8];
  bit          quiet = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : compare
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rwv) begin
          if (exp_q.size() == 0) check("unexpected_strobe", {rwa, rwd}, 32'h0);
          else begin
            e = exp_q.pop_front();
            check("strobe_addr", rwa, e[15:8]);
            check("strobe_data", rwd, e[7:0]);
          end
        end
        if (quiet) begin
          check("quiet_sda_driven", (!tb_sda_low && sda === 1'b0), 0);
          check("quiet_busy", busy, 0);
        end
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wq(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    tb_sda_low = 1'b0; wq(); scl = 1'b1; wq(); tb_sda_low = 1'b1; wq(); scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    tb_sda_low = 1'b1; wq(); scl = 1'b1; wq(); tb_sda_low = 1'b0; wq(2);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    tb_sda_low = ~b; wq(); scl = 1'b1; wq();
    if (glitch) begin
      scl = 1'b0; repeat (2) @(negedge clk); scl = 1'b1; repeat (4) @(negedge clk);
      tb_sda_low = ~tb_sda_low; repeat (2) @(negedge clk); tb_sda_low = ~tb_sda_low;
    end
    wq(); scl = 1'b0; wq();
  endtask

  task automatic recv_bit(output logic b);
    tb_sda_low = 1'b0; wq(); scl = 1'b1; wq(); b = sda; wq(); scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output bit ack, input int glitch_bit);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
    recv_bit(b);
    ack = (b == 1'b0);
  endtask

  task automatic read_byte(output logic [7:0] d, input bit ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin recv_bit(b); d[i] = b; end
    send_bit(!ack, 1'b0);
  endtask

  task automatic bus_write(input logic [7:0] ra, input int n, input bit do_stop, input int glitch_byte);
    bit ack;
    logic [7:0] a;
    i2c_start();
    write_byte(8'h72, ack, -1);
    check("wr_addr_ack", ack, 1);
    check("busy_after_match", busy, 1);
    write_byte(ra, ack, -1);
    check("reg_ack", ack, 1);
    a = ra;
    ptr = ra;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a, wdat[i]});
      mem[a] = wdat[i];
      a = a + 8'd1;
      ptr = a;
      write_byte(wdat[i], ack, (glitch_byte == i) ? 3 : -1);
      check("data_ack", ack, 1);
    end
    if (do_stop) begin
      i2c_stop();
      check("strobes_pending", exp_q.size(), 0);
      check("busy_after_stop", busy, 0);
    end
  endtask

  task automatic bus_read(input int n);
    bit ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h73, ack, -1);
    check("rd_addr_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(d, i != n - 1);
      rd[i] = d;
      check("read_data", d, mem[ptr]);
      ptr = ptr + 8'd1;
    end
    check("nack_release", sda, 1);
    i2c_stop();
    check("busy_after_read", busy, 0);
  endtask

  task automatic cfg_check(input logic [7:0] a);
    cfg_addr = a;
    @(negedge clk);
    check("cfg_read", cfg_data, mem[a]);
  endtask

  task automatic cfg_lit(input logic [7:0] a, input logic [7:0] v);
    cfg_addr = a;
    @(negedge clk);
    check("cfg_literal", cfg_data, v);
  endtask

  initial begin
    bit ack;
    logic b;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    repeat (5) @(negedge clk);
    check("rst_valid", rwv, 0);
    check("rst_waddr", rwa, 0);
    check("rst_wdata", rwd, 0);
    check("rst_cfg", cfg_data, 0);
    check("rst_busy", busy, 0);
    check("rst_sda", sda, 1);
    rst_n = 1'b1;
    wq(2);

    // Basic single write
    wdat[0] = 8'h10;
    bus_write(8'h41, 1, 1, -1);
    cfg_lit(8'h41, 8'h10);

    // Foreign address: no ACK, no strobe, busy stays low
    quiet = 1'b1;
    i2c_start();
    write_byte(8'h70, ack, -1); check("foreign_addr_nack", ack, 0);
    write_byte(8'h41, ack, -1); check("foreign_reg_nack", ack, 0);
    write_byte(8'h55, ack, -1); check("foreign_data_nack", ack, 0);
    i2c_stop();
    quiet = 1'b0;
    cfg_lit(8'h41, 8'h10);

    // Burst with pointer wrap
    wdat[0] = 8'hAA; wdat[1] = 8'hBB;
    bus_write(8'hFF, 2, 1, -1);
    cfg_lit(8'hFF, 8'hAA);
    cfg_lit(8'h00, 8'hBB);

    wdat[0] = 8'h5A; wdat[1] = 8'hC3;
    bus_write(8'h42, 2, 1, -1);

    // Pointer write, repeated START, two-byte read
    bus_write(8'h41, 0, 0, -1);
    bus_read(2);
    check("rd0_literal", rd[0], 8'h10);
    check("rd1_literal", rd[1], 8'h5A);
    check("ptr_model_literal", ptr, 8'h43);
    bus_read(1);
    check("ptr_persist_literal", rd[0], 8'hC3);

    // STOP in the middle of a data byte
    bus_write(8'h41, 0, 0, -1);
    for (int i = 7; i >= 4; i--) send_bit(1'b1, 1'b0);
    i2c_stop();
    check("partial_no_strobe", exp_q.size(), 0);
    cfg_lit(8'h41, 8'h10);
    wdat[0] = 8'h77;
    bus_write(8'h41, 1, 1, -1);
    cfg_lit(8'h41, 8'h77);

    // Short glitches: fake START in idle, then an address clocked without a real START
    quiet = 1'b1;
    tb_sda_low = 1'b1; repeat (2) @(negedge clk); tb_sda_low = 1'b0;
    repeat (2) @(negedge clk);
    scl = 1'b0; repeat (2) @(negedge clk); scl = 1'b1;
    wq(2);
    scl = 1'b0; wq();
    write_byte(8'h72, ack, -1);
    check("glitch_start_ignored", ack, 0);
    i2c_stop();
    quiet = 1'b0;
    // SCL and SDA glitches inside a data bit of a real write
    wdat[0] = 8'h3C;
    bus_write(8'h60, 1, 1, 0);
    cfg_lit(8'h60, 8'h3C);

    // Randomized transactions in a small address window
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) wdat[j] = 8'($urandom);
        bus_write(8'h80 + 8'($urandom_range(0, 7)), n, 1, -1);
      end else begin
        if ($urandom_range(0, 1) == 1) bus_write(8'h80 + 8'($urandom_range(0, 7)), 0, 0, -1);
        bus_read($urandom_range(1, 3));
      end
      cfg_check(8'h80 + 8'($urandom_range(0, 9)));
      cfg_check(ptr - 8'd1);
    end

    // Reset while the target is pulling SDA low during a read
    wdat[0] = 8'h21;
    bus_write(8'h20, 1, 1, -1);
    bus_write(8'h20, 0, 0, -1);
    i2c_start();
    write_byte(8'h73, ack, -1);
    check("rst_test_addr_ack", ack, 1);
    check("read_drive_low", sda, 0);
    rst_n = 1'b0;
    #1;
    check("reset_releases_sda", sda, 1);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    ptr = 8'h00;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 7; i++) recv_bit(b);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) recv_bit(b);
    i2c_stop();
    quiet = 1'b0;
    cfg_lit(8'h20, 8'h00);
    wdat[0] = 8'h99;
    bus_write(8'h30, 1, 1, -1);
    cfg_lit(8'h30, 8'h99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
